// File: rtl/ap_ctrl_perf_monitor_if.sv
// rtl/ap_ctrl_perf_monitor_if.sv - per-channel ap_ctrl handshake bundle watched by the perf monitor
interface ap_ctrl_perf_monitor_if #(
   parameter int N_CH = 4
) ();
   logic [N_CH-1:0] ap_start;
   logic [N_CH-1:0] ap_ready;
   logic [N_CH-1:0] ap_done;
   logic [N_CH-1:0] ap_continue;

   modport master (
      output ap_start,
      output ap_ready,
      output ap_done,
      output ap_continue
   );

   modport slave (
      input ap_start,
      input ap_ready,
      input ap_done,
      input ap_continue
   );
endinterface

// File: rtl/ap_ctrl_perf_monitor.sv
// rtl/ap_ctrl_perf_monitor.sv - N-channel ap_ctrl handshake performance monitor with registered readout
module ap_ctrl_perf_monitor #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 32,
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   ap_ctrl_perf_monitor_if.slave ap,
   input  logic                 finish,
   input  logic                 clear,
   input  logic [CH_W-1:0]      rd_ch,
   input  logic [2:0]           rd_sel,
   output logic [CNT_W-1:0]     rd_data,
   output logic                 frozen,
   output logic [N_CH-1:0]      ovf,
   output logic [N_CH-1:0]      proto_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t           state     [N_CH];
   state_t           state_nxt [N_CH];
   logic [CNT_W-1:0] lat_cnt   [N_CH];
   logic [CNT_W-1:0] lat_nxt   [N_CH];
   logic [CNT_W-1:0] lat_rec   [N_CH];

   logic [CNT_W-1:0] inv_cnt   [N_CH];
   logic [CNT_W-1:0] last_cnt  [N_CH];
   logic [CNT_W-1:0] min_cnt   [N_CH];
   logic [CNT_W-1:0] max_cnt   [N_CH];
   logic [CNT_W-1:0] busy_cnt  [N_CH];
   logic [CNT_W-1:0] stall_cnt [N_CH];
   logic [CNT_W-1:0] ready_cnt [N_CH];

   logic [N_CH-1:0]  rec;
   logic [N_CH-1:0]  busy_hit;
   logic [N_CH-1:0]  stall_hit;
   logic [N_CH-1:0]  perr_hit;
   logic [N_CH-1:0]  lat_sat;
   logic [N_CH-1:0]  ovf_hit;
   logic [CNT_W-1:0] rd_mux;
   logic             stat_en;

   // Statistics stop changing from the edge that samples finish onward.
   assign stat_en = ~(frozen | finish);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Channel FSM next state, latency tracking and per-cycle statistic events.
   always_comb begin
      rec       = '0;
      busy_hit  = '0;
      stall_hit = '0;
      perr_hit  = '0;
      lat_sat   = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         state_nxt[ch] = state[ch];
         lat_nxt[ch]   = lat_cnt[ch];
         lat_rec[ch]   = '0;
         case (state[ch])
            ST_IDLE: begin
               if (ap.ap_start[ch]) begin
                  busy_hit[ch] = 1'b1;
                  lat_nxt[ch]  = CNT_W'(1);
                  if (ap.ap_done[ch]) begin
                     rec[ch]       = 1'b1;
                     lat_rec[ch]   = CNT_W'(1);
                     state_nxt[ch] = ap.ap_continue[ch] ? ST_IDLE : ST_HOLD;
                  end else begin
                     state_nxt[ch] = ST_RUN;
                  end
               end else if (ap.ap_done[ch]) begin
                  perr_hit[ch] = 1'b1;
               end
            end
            ST_RUN: begin
               busy_hit[ch] = 1'b1;
               lat_nxt[ch]  = sat_inc(lat_cnt[ch]);
               lat_sat[ch]  = &lat_cnt[ch];
               if (ap.ap_done[ch]) begin
                  rec[ch]       = 1'b1;
                  lat_rec[ch]   = sat_inc(lat_cnt[ch]);
                  state_nxt[ch] = ap.ap_continue[ch] ? ST_IDLE : ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (ap.ap_continue[ch]) begin
                  state_nxt[ch] = ST_IDLE;
               end else begin
                  stall_hit[ch] = 1'b1;
               end
            end
            default: state_nxt[ch] = ST_IDLE;
         endcase
      end
   end

   // A counter that would step past all-ones flags its channel's sticky ovf.
   always_comb begin
      ovf_hit = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         ovf_hit[ch] = (rec[ch] & (&inv_cnt[ch]))
                     | (busy_hit[ch] & (&busy_cnt[ch]))
                     | (stall_hit[ch] & (&stall_cnt[ch]))
                     | (ap.ap_ready[ch] & (&ready_cnt[ch]))
                     | lat_sat[ch];
      end
   end

   // Channel FSM and in-flight latency registers; only reset disturbs them.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int ch = 0; ch < N_CH; ch++) begin
            state[ch]   <= ST_IDLE;
            lat_cnt[ch] <= '0;
         end
      end else begin
         for (int ch = 0; ch < N_CH; ch++) begin
            state[ch]   <= state_nxt[ch];
            lat_cnt[ch] <= lat_nxt[ch];
         end
      end
   end

   // Statistic counters, sticky flags and freeze; clear beats same-cycle increments.
   always_ff @(posedge clock) begin
      if (!reset) begin
         frozen    <= 1'b0;
         ovf       <= '0;
         proto_err <= '0;
         for (int ch = 0; ch < N_CH; ch++) begin
            inv_cnt[ch]   <= '0;
            last_cnt[ch]  <= '0;
            min_cnt[ch]   <= '1;
            max_cnt[ch]   <= '0;
            busy_cnt[ch]  <= '0;
            stall_cnt[ch] <= '0;
            ready_cnt[ch] <= '0;
         end
      end else begin
         if (finish) frozen <= 1'b1;
         if (stat_en) begin
            if (clear) begin
               ovf       <= '0;
               proto_err <= '0;
               for (int ch = 0; ch < N_CH; ch++) begin
                  inv_cnt[ch]   <= '0;
                  last_cnt[ch]  <= '0;
                  min_cnt[ch]   <= '1;
                  max_cnt[ch]   <= '0;
                  busy_cnt[ch]  <= '0;
                  stall_cnt[ch] <= '0;
                  ready_cnt[ch] <= '0;
               end
            end else begin
               for (int ch = 0; ch < N_CH; ch++) begin
                  if (rec[ch]) begin
                     inv_cnt[ch]  <= sat_inc(inv_cnt[ch]);
                     last_cnt[ch] <= lat_rec[ch];
                     if (lat_rec[ch] < min_cnt[ch]) min_cnt[ch] <= lat_rec[ch];
                     if (lat_rec[ch] > max_cnt[ch]) max_cnt[ch] <= lat_rec[ch];
                  end
                  if (busy_hit[ch])       busy_cnt[ch]  <= sat_inc(busy_cnt[ch]);
                  if (stall_hit[ch])      stall_cnt[ch] <= sat_inc(stall_cnt[ch]);
                  if (ap.ap_ready[ch])    ready_cnt[ch] <= sat_inc(ready_cnt[ch]);
                  if (perr_hit[ch])       proto_err[ch] <= 1'b1;
                  if (ovf_hit[ch])        ovf[ch]       <= 1'b1;
               end
            end
         end
      end
   end

   // Readout select; out-of-range channels read as zero.
   always_comb begin
      logic [3:0] st4;
      int         idx;
      rd_mux = '0;
      st4    = '0;
      idx    = int'(rd_ch);
      if (idx < N_CH) begin
         st4 = {proto_err[idx], ovf[idx], 2'(state[idx])};
         case (rd_sel)
            3'd0:    rd_mux = inv_cnt[idx];
            3'd1:    rd_mux = last_cnt[idx];
            3'd2:    rd_mux = min_cnt[idx];
            3'd3:    rd_mux = max_cnt[idx];
            3'd4:    rd_mux = busy_cnt[idx];
            3'd5:    rd_mux = stall_cnt[idx];
            3'd6:    rd_mux = ready_cnt[idx];
            default: rd_mux = CNT_W'(st4);
         endcase
      end
   end

   // Registered readout port, live even while frozen.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= rd_mux;
      end
   end

endmodule
